// File: rtl/lite_slv_pkg.sv
// Shared definitions for the AXI-Lite register responder.
//   ADDR_W / DATA_W : bus address and data widths
//   IDX_W / STRB_W  : register index width (word address) and byte-lane count
//   RESP_*          : AXI response encodings
//   wr_state_e      : write channel FSM states
//   rd_state_e      : read channel FSM states
package lite_slv_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/lite_slv_rd_chan.sv
// AXI-Lite read channel: single-outstanding read FSM plus read decode mux.
//   clk, rst      : clock, asynchronous active-low reset
//   ar_idx_i      : word index of the read address (addr[9:2])
//   arvalid_i/arready_o, rvalid_o/rready_i : AR and R handshakes
//   rdata_o/rresp_o : registered read payload, stable while rvalid_o is high
//   regs_i        : flattened RW register bus (register i at [32*i+31:32*i])
//   status_i      : value returned for index NUM_REGS, sampled at the AR handshake
module lite_slv_rd_chan
    import lite_slv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IDX_W-1:0]           ar_idx_i,
    input  logic                       arvalid_i,
    output logic                       arready_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [1:0]                 rresp_o,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    input  logic [DATA_W*NUM_REGS-1:0] regs_i,
    input  logic [DATA_W-1:0]          status_i
);

    localparam logic [IDX_W-1:0] NREG_IDX = IDX_W'(NUM_REGS);

    rd_state_e         state_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_resp;

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ar_idx_i == IDX_W'(i)) begin
                rd_data = regs_i[DATA_W*i +: DATA_W];
                rd_resp = RESP_OKAY;
            end
        end
        if (ar_idx_i == NREG_IDX) begin
            rd_data = status_i;
            rd_resp = RESP_OKAY;
        end
    end

    // Capture samples the register bus before any same-edge write lands,
    // so a colliding write is not visible to this read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (arvalid_i) begin
                        state_q <= R_DATA;
                        rdata_q <= rd_data;
                        rresp_q <= rd_resp;
                    end
                end
                R_DATA: begin
                    if (rready_i) begin
                        state_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign arready_o = (state_q == R_IDLE);
    assign rvalid_o  = (state_q == R_DATA);
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule

// File: rtl/lite_slave_regs.sv
// AXI-Lite responder exposing NUM_REGS RW configuration registers at byte
// address 4*i and a read-only status word at 4*NUM_REGS.
//   clk, rst                 : clock, asynchronous active-low reset
//   s_axi_lite_aw*/w*/b*     : write address, data and response channels
//   s_axi_lite_ar*/r*        : read address and data channels
//   cfg_regs                 : flattened register contents, register i at [32*i+31:32*i]
//   cfg_wr_pulse             : bit i pulses for one cycle after register i is written
//   status_in                : value returned by reads of the status address
// Optional macro LITE_SLV_WSTRB_EN adds s_axi_lite_wstrb for byte-lane writes.
module lite_slave_regs
    import lite_slv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          s_axi_lite_awaddr,
    input  logic                       s_axi_lite_awvalid,
    output logic                       s_axi_lite_awready,
    input  logic [DATA_W-1:0]          s_axi_lite_wdata,
`ifdef LITE_SLV_WSTRB_EN
    input  logic [STRB_W-1:0]          s_axi_lite_wstrb,
`endif
    input  logic                       s_axi_lite_wvalid,
    output logic                       s_axi_lite_wready,
    output logic [1:0]                 s_axi_lite_bresp,
    output logic                       s_axi_lite_bvalid,
    input  logic                       s_axi_lite_bready,
    input  logic [ADDR_W-1:0]          s_axi_lite_araddr,
    input  logic                       s_axi_lite_arvalid,
    output logic                       s_axi_lite_arready,
    output logic [DATA_W-1:0]          s_axi_lite_rdata,
    output logic [1:0]                 s_axi_lite_rresp,
    output logic                       s_axi_lite_rvalid,
    input  logic                       s_axi_lite_rready,
    output logic [DATA_W*NUM_REGS-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]        cfg_wr_pulse,
    input  logic [DATA_W-1:0]          status_in
);

    localparam logic [IDX_W-1:0] NREG_IDX = IDX_W'(NUM_REGS);

    wr_state_e           w_state_q;
    logic                aw_held_q;
    logic                w_held_q;
    logic [IDX_W-1:0]    awidx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          bresp_q;
    logic [NUM_REGS-1:0] pulse_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                aw_hs;
    logic                w_hs;
    logic                commit;
    logic                cm_hit;
    logic [IDX_W-1:0]    cm_idx;
    logic [DATA_W-1:0]   cm_data;
    logic [STRB_W-1:0]   cm_strb;
    logic [NUM_REGS-1:0] wr_sel;

    // Byte-offset bits are ignored by design.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

    // Readies depend only on state and latches, never on the valids.
    assign s_axi_lite_awready = (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axi_lite_wready  = (w_state_q == W_IDLE) && !w_held_q;

    assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
    assign w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;

    // Commit as soon as both halves are present, latched or arriving now.
    assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign cm_idx  = aw_held_q ? awidx_q : s_axi_lite_awaddr[ADDR_W-1:2];
    assign cm_data = w_held_q ? wdata_q : s_axi_lite_wdata;
    assign cm_hit  = (cm_idx < NREG_IDX);

`ifdef LITE_SLV_WSTRB_EN
    logic [STRB_W-1:0] wstrb_q;
    assign cm_strb = w_held_q ? wstrb_q : s_axi_lite_wstrb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstrb_q <= '0;
        end else if (w_hs) begin
            wstrb_q <= s_axi_lite_wstrb;
        end
    end
`else
    assign cm_strb = '1;
`endif

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = commit && (cm_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= '0;
        end else begin
            // The pulse fires on any accepted write, whatever the strobes.
            pulse_q <= wr_sel;
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awidx_q   <= s_axi_lite_awaddr[ADDR_W-1:2];
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= s_axi_lite_wdata;
                    end
                    if (commit) begin
                        w_state_q <= W_RESP;
                        bresp_q   <= cm_hit ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (s_axi_lite_bready) begin
                        w_state_q <= W_IDLE;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wr_sel[i] && cm_strb[b]) begin
                        regs_q[i][8*b +: 8] <= cm_data[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[DATA_W*g +: DATA_W] = regs_q[g];
    end

    assign s_axi_lite_bvalid = (w_state_q == W_RESP);
    assign s_axi_lite_bresp  = bresp_q;
    assign cfg_wr_pulse      = pulse_q;

    lite_slv_rd_chan #(
        .NUM_REGS (NUM_REGS)
    ) u_rd_chan (
        .clk       (clk),
        .rst       (rst),
        .ar_idx_i  (s_axi_lite_araddr[ADDR_W-1:2]),
        .arvalid_i (s_axi_lite_arvalid),
        .arready_o (s_axi_lite_arready),
        .rdata_o   (s_axi_lite_rdata),
        .rresp_o   (s_axi_lite_rresp),
        .rvalid_o  (s_axi_lite_rvalid),
        .rready_i  (s_axi_lite_rready),
        .regs_i    (cfg_regs),
        .status_i  (status_in)
    );

endmodule

// File: doc/lite_slave_regs.md
# lite_slave_regs

AXI-Lite responder that terminates the 10-bit-address, 32-bit-data AXI-Lite bus driven by the DMA controller's lite initiator. It exposes a bank of read/write configuration registers plus one read-only status register to the DMA datapath. Write and read channels run independently, each as its own small FSM. The block supports a single outstanding transaction per direction.

## Interface
- NUM_REGS, 8, number of RW registers (1..63); RW register i at byte address 4*i
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- s_axi_lite_awaddr  input  10  write address (bits [1:0] ignored)
- s_axi_lite_awvalid  input  1  write address valid
- s_axi_lite_awready  output  1  write address ready
- s_axi_lite_wdata  input  32  write data
- s_axi_lite_wvalid  input  1  write data valid
- s_axi_lite_wready  output  1  write data ready
- s_axi_lite_bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- s_axi_lite_bvalid  output  1  write response valid
- s_axi_lite_bready  input  1  write response ready
- s_axi_lite_araddr  input  10  read address (bits [1:0] ignored)
- s_axi_lite_arvalid  input  1  read address valid
- s_axi_lite_arready  output  1  read address ready
- s_axi_lite_rdata  output  32  read data
- s_axi_lite_rresp  output  2  read response
- s_axi_lite_rvalid  output  1  read data valid
- s_axi_lite_rready  input  1  read data ready
- cfg_regs  output  32*NUM_REGS  flattened RW register contents; register i at [32*i+31:32*i]
- cfg_wr_pulse  output  NUM_REGS  one-cycle pulse, bit i set in the cycle after register i is written
- status_in  input  32  value returned for reads of byte address 4*NUM_REGS

## Operation
- Address index = addr[9:2].
- Write FSM states:
  - W_IDLE: awready = !aw_held; wready = !w_held. AW and W are captured independently, in any order, into aw_held/w_held latches.
  - When both are held (or both handshakes complete in the same cycle): commit, then move to W_RESP.
  - W_RESP: awready = wready = 0; bvalid = 1; bresp is stable. On bvalid & bready, clear the latches and return to W_IDLE.
- Write decode:
  - index < NUM_REGS: update the register, bresp OKAY.
  - Any other index, including the status address: no register change, no pulse, bresp SLVERR.
- Read FSM states:
  - R_IDLE: arready = 1. On arvalid, capture rdata/rresp and move to R_DATA.
  - R_DATA: arready = 0; rvalid = 1; rdata/rresp are stable. On rready, return to R_IDLE.
- Read decode:
  - index < NUM_REGS: register value, OKAY.
  - index == NUM_REGS: status_in sampled at the AR handshake, OKAY.
  - Otherwise: rdata = 0, SLVERR.
- Simultaneous write commit and AR handshake to the same register: the read returns the old value.
- Reset (asserted asynchronously, at any time including mid-transaction):
  - Both FSMs return to idle; latches cleared; registers = 0.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; cfg_wr_pulse = 0.
  - awready = wready = arready = 1. Any in-flight transaction is dropped and no response is issued.

## Timing
- Write: final AW/W handshake in cycle N → register value, cfg_wr_pulse, and bvalid are all visible in cycle N+1. Next awready/wready is earliest in the cycle after the B handshake.
- Read: AR handshake in cycle N → rvalid/rdata visible in N+1. The next arready is earliest in the cycle after the R handshake.
- Back-to-back throughput with bready/rready tied high: one write every 2 cycles and one read every 2 cycles, concurrently.
- The ready outputs are decoded from state and latch registers only; there is no combinational path from any valid input to any ready output.
- bvalid/rvalid are held, with stable payload, until accepted.

## Configuration
- LITE_SLV_WSTRB_EN defined:
  - Adds port s_axi_lite_wstrb (input, 4 bits), captured together with wdata.
  - Byte lane k of the target register is updated only if wstrb[k] = 1.
  - cfg_wr_pulse fires even when wstrb = 0.
- LITE_SLV_WSTRB_EN undefined: no wstrb port; every write updates all 4 bytes.

## Structure
- Package lite_slv_pkg contains:
  - RESP_OKAY (2'b00) and RESP_SLVERR (2'b10).
  - Write-state enum (W_IDLE, W_RESP) and read-state enum (R_IDLE, R_DATA).
  - ADDR_W = 10 and DATA_W = 32.
- Sub-module lite_slv_rd_chan: contains the read FSM and read decode mux. Inputs are the flattened register bus and status_in. The top level owns the write channel and the register storage.

## Test plan
- Reset release → awready = wready = arready = 1, all cfg_regs = 0; write 0xDEADBEEF to 0x004 with AW/W in the same cycle → bvalid with OKAY next cycle; cfg_regs[63:32] = 0xDEADBEEF; cfg_wr_pulse = 8'h02 for exactly one cycle.
- W presented 3 cycles before AW (write 0x12345678 to 0x000) → wready drops after the W handshake; commit occurs the cycle after AW; read of 0x000 returns 0x12345678 OKAY.
- Write to 0x020 (status, NUM_REGS = 8) and to 0x3FC → bresp SLVERR, no register change, no pulse; read 0x020 with status_in = 0xA5A5A5A5 → rdata 0xA5A5A5A5 OKAY; read 0x3FC → rdata 0, SLVERR.
- Hold bready = 0 for 5 cycles and rready = 0 for 4 cycles → bvalid/bresp and rvalid/rdata stable throughout; awready/wready and arready remain 0 until the respective handshake.
- AR handshake to 0x008 (contents 0x1) in the same cycle as a write commit of 0x2 to 0x008 → rdata = 0x1; a subsequent read returns 0x2.
- Assert rst while bvalid = 1 and rvalid = 1 → both drop immediately and all registers = 0; after release, a new write completes normally. With LITE_SLV_WSTRB_EN: write 0xFFFFFFFF with wstrb = 4'b0101 to a register holding 0 → register = 0x00FF00FF.
